// File: rtl/button_debounce_multi_if.sv
// Button conditioner bus: raw button inputs in, conditioned level and pulses out.
interface button_debounce_multi_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] i_btn;
    logic [N_BTN-1:0] o_level;
    logic [N_BTN-1:0] o_press;
    logic [N_BTN-1:0] o_release;
    logic [N_BTN-1:0] o_repeat;

    // Button/consumer side drives the raw buttons and reads the results.
    modport master (
        output i_btn,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_repeat
    );

    // Conditioner side.
    modport slave (
        input  i_btn,
        output o_level,
        output o_press,
        output o_release,
        output o_repeat
    );
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel button conditioner: 2-FF sync, tick-sampled symmetric debounce with
// hysteresis, one-clock press/release pulses and hold-to-auto-repeat per channel.
module button_debounce_multi #(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned TICK_DIV     = 100,
    parameter int unsigned N_SAMPLE     = 4,
    parameter int unsigned LONG_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    button_debounce_multi_if.slave  bus
);
    localparam int unsigned TW       = $clog2(TICK_DIV);
    localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] LONG_C    = HW'(LONG_TICKS);
    localparam logic [HW-1:0] REP_C     = HW'(REPEAT_TICKS);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;

    logic [TW-1:0]       tick_cnt_q;
    logic                tick;
    logic [N_BTN-1:0]    sync1_q, sync2_q;
    logic [N_SAMPLE-1:0] samp_q [N_BTN];
    logic [N_SAMPLE-1:0] samp_d [N_BTN];
    logic [N_BTN-1:0]    all_ones, all_zeros;
    state_e              state_q [N_BTN];
    logic [HW-1:0]       hold_q [N_BTN];
    logic [N_BTN-1:0]    level_q, press_q, rel_q, rpt_q;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Shared sample-tick divider, wraps after the tick cycle.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Two-stage synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.i_btn;
            sync2_q <= sync1_q;
        end
    end

    // Next sample window (newest in MSB) and its unanimity flags.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            samp_d[i]    = {sync2_q[i], samp_q[i][N_SAMPLE-1:1]};
            all_ones[i]  = &samp_d[i];
            all_zeros[i] = ~|samp_d[i];
        end
    end

    // Debounce + per-channel IDLE/HELD/REPEAT FSM with registered pulse outputs.
    // Level edges are checked first so a release suppresses a coincident repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                samp_q[i]  <= '0;
                state_q[i] <= StIdle;
                hold_q[i]  <= '0;
            end
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            rpt_q   <= '0;
        end else begin
            press_q <= '0;
            rel_q   <= '0;
            rpt_q   <= '0;
            if (tick) begin
                for (int i = 0; i < N_BTN; i++) begin
                    samp_q[i] <= samp_d[i];
                    if (!level_q[i] && all_ones[i]) begin
                        level_q[i] <= 1'b1;
                        press_q[i] <= 1'b1;
                        state_q[i] <= StHeld;
                        hold_q[i]  <= '0;
                    end else if (level_q[i] && all_zeros[i]) begin
                        level_q[i] <= 1'b0;
                        rel_q[i]   <= 1'b1;
                        state_q[i] <= StIdle;
                        hold_q[i]  <= '0;
                    end else begin
                        unique case (state_q[i])
                            StHeld: begin
                                if (LONG_TICKS != 0) begin
                                    if (hold_q[i] + HOLD_ONE == LONG_C) begin
                                        rpt_q[i]   <= 1'b1;
                                        hold_q[i]  <= '0;
                                        state_q[i] <= StRepeat;
                                    end else begin
                                        hold_q[i] <= hold_q[i] + HOLD_ONE;
                                    end
                                end
                            end
                            StRepeat: begin
                                if (hold_q[i] + HOLD_ONE == REP_C) begin
                                    rpt_q[i]  <= 1'b1;
                                    hold_q[i] <= '0;
                                end else begin
                                    hold_q[i] <= hold_q[i] + HOLD_ONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.o_level   = level_q;
    assign bus.o_press   = press_q;
    assign bus.o_release = rel_q;
    assign bus.o_repeat  = rpt_q;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi (2 channels, TICK_DIV=4, N_SAMPLE=4,
// LONG_TICKS=3, REPEAT_TICKS=2).
module tb_button_debounce_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    button_debounce_multi_if #(.N_BTN(2)) bus ();

    button_debounce_multi #(
        .N_BTN       (2),
        .TICK_DIV    (4),
        .N_SAMPLE    (4),
        .LONG_TICKS  (3),
        .REPEAT_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst = 1'b1;
        bus.i_btn = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            outs = {bus.o_level, bus.o_press, bus.o_release, bus.o_repeat};
            checks++;
            if (outs !== 8'h00) begin
                errors++;
                $display("FAIL reset_outs: got %h expected 00", outs);
            end
        end
        rst = 1'b0;
        bus.i_btn = 2'b00;
        // Cycles 1..4 after release: tick only in the 4th.
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut.tick !== (k == 3)) begin
                errors++;
                $display("FAIL reset_tick cycle %0d: got %b expected %b", k + 1, dut.tick, k == 3);
            end
            if (k == 1) begin
                outs = {bus.o_level, bus.o_press, bus.o_release, bus.o_repeat};
                checks++;
                if (outs !== 8'h00) begin
                    errors++;
                    $display("FAIL post_reset_outs: got %h expected 00", outs);
                end
            end
            if (k < 3) step();
        end
    endtask

    task automatic test_press();
        int  n = 0;
        bit  ch1_seen = 0;
        bus.i_btn[0] = 1'b1;
        while (n < 19 && bus.o_level[0] !== 1'b1) begin
            step();
            n++;
            if ({bus.o_level[1], bus.o_press[1], bus.o_release[1], bus.o_repeat[1]} !== 4'b0)
                ch1_seen = 1;
        end
        checks++;
        if (bus.o_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL press_latency: level0=%b after %0d clks, expected 1 within 19", bus.o_level[0], n);
        end
        checks++;
        if (bus.o_press[0] !== 1'b1) begin
            errors++;
            $display("FAIL press_pulse: got %b expected 1", bus.o_press[0]);
        end
        step();
        checks++;
        if (bus.o_press[0] !== 1'b0 || bus.o_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL press_width: press0=%b level0=%b expected 0/1", bus.o_press[0], bus.o_level[0]);
        end
        checks++;
        if (ch1_seen) begin
            errors++;
            $display("FAIL press_ch1_quiet: got activity expected none");
        end
        // Release ch0 for the next scenario.
        bus.i_btn[0] = 1'b0;
        n = 0;
        while (n < 25 && bus.o_level[0] !== 1'b0) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_level[0] !== 1'b0 || bus.o_release[0] !== 1'b1) begin
            errors++;
            $display("FAIL press_release: level0=%b release0=%b expected 0/1", bus.o_level[0], bus.o_release[0]);
        end
    endtask

    task automatic test_bounce();
        bit activity = 0;
        int presses = 0;
        int n = 0;
        for (int c = 0; c < 60; c++) begin
            bus.i_btn[0] = ((c / 5) % 2 == 0);
            step();
            if (bus.o_level[0] || bus.o_press[0] || bus.o_release[0] || bus.o_repeat[0]) activity = 1;
        end
        checks++;
        if (activity) begin
            errors++;
            $display("FAIL bounce_quiet: got activity expected level0=0 and no pulses");
        end
        bus.i_btn[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.o_press[0]) presses++;
        end
        checks++;
        if (presses !== 1 || bus.o_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_hold: presses=%0d level0=%b expected 1/1", presses, bus.o_level[0]);
        end
        bus.i_btn[0] = 1'b0;
        while (n < 25 && bus.o_level[0] !== 1'b0) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release: level0=%b expected 0", bus.o_level[0]);
        end
    endtask

    task automatic test_repeat();
        int n = 0;
        int reps = 0;
        int first = -1;
        int rels = 0;
        bit late = 0;
        bus.i_btn[1] = 1'b1;
        while (n < 25 && bus.o_press[1] !== 1'b1) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_press[1] !== 1'b1) begin
            errors++;
            $display("FAIL repeat_press: press1=%b expected 1 within 25 clks", bus.o_press[1]);
        end
        for (int j = 1; j <= 160; j++) begin
            step();
            if (bus.o_repeat[1]) begin
                reps++;
                if (first < 0) first = j;
            end
        end
        checks++;
        if (first !== 12) begin
            errors++;
            $display("FAIL repeat_first: got clk %0d expected 12", first);
        end
        checks++;
        if (reps !== 19) begin
            errors++;
            $display("FAIL repeat_count: got %0d expected 19", reps);
        end
        bus.i_btn[1] = 1'b0;
        n = 0;
        while (n < 25 && bus.o_release[1] !== 1'b1) begin
            step();
            n++;
        end
        if (bus.o_release[1]) rels++;
        for (int j = 0; j < 40; j++) begin
            step();
            if (bus.o_repeat[1] || bus.o_level[1]) late = 1;
            if (bus.o_release[1]) rels++;
        end
        checks++;
        if (rels !== 1 || late) begin
            errors++;
            $display("FAIL repeat_release: releases=%0d late_activity=%b expected 1/0", rels, late);
        end
    endtask

    task automatic test_release_boundary();
        int n = 0;
        int reps = 0;
        bus.i_btn[1] = 1'b1;
        while (n < 25 && bus.o_press[1] !== 1'b1) begin
            step();
            n++;
        end
        n = 0;
        while (n < 20 && bus.o_repeat[1] !== 1'b1) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_repeat[1] !== 1'b1) begin
            errors++;
            $display("FAIL boundary_first_repeat: repeat1=%b expected 1", bus.o_repeat[1]);
        end
        // Fall lands 4 ticks later, exactly on the second repeat expiry.
        bus.i_btn[1] = 1'b0;
        n = 0;
        while (n < 25 && bus.o_release[1] !== 1'b1) begin
            step();
            n++;
            if (bus.o_repeat[1] && !bus.o_release[1]) reps++;
        end
        checks++;
        if (n !== 16 || bus.o_release[1] !== 1'b1) begin
            errors++;
            $display("FAIL boundary_timing: release1=%b at clk %0d expected 1 at 16", bus.o_release[1], n);
        end
        checks++;
        if (bus.o_repeat[1] !== 1'b0) begin
            errors++;
            $display("FAIL boundary_no_repeat: got %b expected 0", bus.o_repeat[1]);
        end
        checks++;
        if (reps !== 1) begin
            errors++;
            $display("FAIL boundary_mid_repeats: got %0d expected 1", reps);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int  n = 0;
        bit  rel_seen = 0;
        logic [7:0] outs;
        bus.i_btn[1] = 1'b1;
        while (n < 25 && bus.o_press[1] !== 1'b1) begin
            step();
            n++;
        end
        n = 0;
        while (n < 20 && bus.o_repeat[1] !== 1'b1) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        outs = {bus.o_level, bus.o_press, bus.o_release, bus.o_repeat};
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outs: got %h expected 00", outs);
        end
        n = 0;
        while (n < 20 && bus.o_press[1] !== 1'b1) begin
            step();
            n++;
            if (bus.o_release[1]) rel_seen = 1;
        end
        checks++;
        if (n !== 16 || bus.o_press[1] !== 1'b1 || rel_seen) begin
            errors++;
            $display("FAIL midreset_repress: press1=%b at clk %0d release_seen=%b expected 1 at 16, 0",
                     bus.o_press[1], n, rel_seen);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        bus.i_btn = 2'b00;
        while (n < 25 && bus.o_level !== 2'b00) begin
            step();
            n++;
        end
        bus.i_btn = 2'b11;
        n = 0;
        while (n < 25 && bus.o_press === 2'b00) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_press !== 2'b11 || bus.o_level !== 2'b11) begin
            errors++;
            $display("FAIL simultaneous_press: press=%b level=%b expected 11/11", bus.o_press, bus.o_level);
        end
    endtask

    initial begin
        bus.i_btn = 2'b00;
        test_reset();
        test_press();
        test_bounce();
        test_repeat();
        test_release_boundary();
        test_reset_mid_repeat();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
